muldiv_unit: RTL and testbench

Iterative RV32M multiply/divide unit sitting directly downstream of the register file's read ports: it consumes the RD1/RD2 operand pair and produces a 32-bit result for the write-back mux feeding WD. It executes all eight M-extension operations with one shared shift/add datapath. It uses a start/busy/done handshake so the control unit can stall the PC while the operation runs.

---
 rtl/muldiv_unit_if.sv | 16 +
 rtl/muldiv_unit.sv | 135 +++++++++++++
 tb/tb_muldiv_unit.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/muldiv_unit_if.sv
// Start/busy/done handshake between the control unit and the RV32M
// multiply/divide unit: operands from RD1/RD2, result toward the WD mux.
interface muldiv_unit_if #(parameter int XLEN = 32);
  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (output start, funct3, rs1_val, rs2_val,
                  input  busy, done, result);
  modport slave  (input  start, funct3, rs1_val, rs2_val,
                  output busy, done, result);
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: one shared 2*XLEN accumulator does
// radix-2 shift-add multiply or restoring divide on operand magnitudes.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input logic          clk,
  input logic          rst,
  muldiv_unit_if.slave bus
);
  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] ALL_ONES = '1;

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2:0]        op_q, op_d;
  logic              s1_q, s1_d, s2_q, s2_d;
  logic [XLEN-1:0]   b_q, b_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic              busy_q, busy_d, done_q, done_d;
  logic [XLEN-1:0]   result_q, result_d;

  logic              is_div, sg1, sg2, div_zero, ovf, borrow;
  logic [XLEN-1:0]   abs1, abs2, quo, rem;
  logic [XLEN:0]     mul_sum, div_rem, div_diff;
  logic [2*XLEN-1:0] prod;

  always_comb begin
    // Operand view at acceptance: MULHSU keeps rs2 unsigned; U-variants are fully unsigned.
    is_div   = bus.funct3[2];
    sg1      = bus.rs1_val[XLEN-1] & (bus.funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b110});
    sg2      = bus.rs2_val[XLEN-1] & (bus.funct3 inside {3'b000, 3'b001, 3'b100, 3'b110});
    abs1     = sg1 ? -bus.rs1_val : bus.rs1_val;
    abs2     = sg2 ? -bus.rs2_val : bus.rs2_val;
    div_zero = is_div && (bus.rs2_val == '0);
    ovf      = is_div && !bus.funct3[0] && (bus.rs1_val == MIN_NEG) && (bus.rs2_val == ALL_ONES);

    // Multiply step: add multiplicand into the high half when the multiplier LSB is set, shift right.
    mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : '0);
    // Divide step: high half is the remainder, low half shifts dividend out and quotient in.
    div_rem  = acc_q[2*XLEN-1:XLEN-1];
    div_diff = div_rem - {1'b0, b_q};
    borrow   = div_diff[XLEN];

    prod     = (s1_q ^ s2_q) ? -acc_q : acc_q;
    quo      = (s1_q ^ s2_q) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    rem      = s1_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];

    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    s1_d     = s1_q;
    s2_d     = s2_q;
    b_d      = b_q;
    acc_d    = acc_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    result_d = result_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (div_zero) begin
            done_d   = 1'b1;
            result_d = bus.funct3[1] ? bus.rs1_val : ALL_ONES;
          end else if (ovf) begin
            done_d   = 1'b1;
            result_d = bus.funct3[1] ? '0 : MIN_NEG;
          end else begin
            state_d = CALC;
            busy_d  = 1'b1;
            cnt_d   = '0;
            op_d    = bus.funct3;
            s1_d    = sg1;
            s2_d    = sg2;
            b_d     = abs2;
            acc_d   = {{XLEN{1'b0}}, abs1};
          end
        end
      end
      CALC: begin
        if (op_q[2])
          acc_d = {borrow ? div_rem[XLEN-1:0] : div_diff[XLEN-1:0], acc_q[XLEN-2:0], ~borrow};
        else
          acc_d = {mul_sum, acc_q[XLEN-1:1]};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(XLEN-1)) state_d = FIX;
      end
      FIX: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        case (op_q)
          3'b000:          result_d = prod[XLEN-1:0];
          3'b100, 3'b101:  result_d = quo;
          3'b110, 3'b111:  result_d = rem;
          default:         result_d = prod[2*XLEN-1:XLEN];
        endcase
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      b_q      <= '0;
      acc_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: vector table plus handshake corner sequences,
// expected results queued at acceptance and checked when done pulses.
module tb_muldiv_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  muldiv_unit_if #(.XLEN(32)) bus ();
  muldiv_unit #(.XLEN(32)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          dly;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    int          due;
  } sb_t;

  localparam int NV = 17;
  vec_t vecs [NV];
  sb_t  exp_q [$];
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Scoreboard side: every done pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (bus.done === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL spurious_done: got done with result %h want no done (cycle %0d)", bus.result, cyc);
      end else begin
        sb_t e;
        e = exp_q.pop_front();
        chk("result", bus.result, e.res);
        chk("done_cycle", 32'(cyc), 32'(e.due));
      end
    end
  end

  // Called at a negedge; dly is the number of edges after acceptance before done is visible.
  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] r, input int dly);
    bus.start   = 1'b1;
    bus.funct3  = f;
    bus.rs1_val = a;
    bus.rs2_val = b;
    @(posedge clk);
    #1;
    exp_q.push_back('{res: r, due: cyc + dly});
    chk("busy_after_accept", 32'(bus.busy), (dly != 0) ? 32'd1 : 32'd0);
    bus.start = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("completion_timeout", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish before time limit");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33}; // MUL 7*-3
    vecs[1]  = '{3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33}; // MULH
    vecs[2]  = '{3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33}; // MULHU
    vecs[3]  = '{3'b010, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 33}; // MULHSU -1*2
    vecs[4]  = '{3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 33}; // DIV -7/2
    vecs[5]  = '{3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 33}; // REM -7/2
    vecs[6]  = '{3'b101, 32'd100,       32'd7,         32'd14,        33}; // DIVU
    vecs[7]  = '{3'b111, 32'd100,       32'd7,         32'd2,         33}; // REMU
    vecs[8]  = '{3'b101, 32'd5,         32'd0,         32'hFFFF_FFFF, 0};  // DIVU /0
    vecs[9]  = '{3'b111, 32'd5,         32'd0,         32'd5,         0};  // REMU /0
    vecs[10] = '{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0};  // DIV overflow
    vecs[11] = '{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 0};  // REM overflow
    vecs[12] = '{3'b110, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 0};  // REM /0 keeps rs1
    vecs[13] = '{3'b100, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 33}; // DIV 7/-2
    vecs[14] = '{3'b110, 32'd7,         32'hFFFF_FFFE, 32'd1,         33}; // REM 7/-2
    vecs[15] = '{3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         33}; // DIVU, not overflow
    vecs[16] = '{3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1,         33}; // MUL -1*-1

    bus.start   = 1'b0;
    bus.funct3  = 3'b000;
    bus.rs1_val = '0;
    bus.rs2_val = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_result", bus.result, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      issue(vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].dly);
      wait_done();
    end

    // start while busy (a would-be special case) and operand churn must be ignored.
    @(negedge clk);
    issue(3'b101, 32'd1000, 32'd7, 32'd142, 33);
    repeat (9) @(negedge clk);
    bus.start   = 1'b1;
    bus.funct3  = 3'b110;
    bus.rs1_val = 32'd55;
    bus.rs2_val = 32'd0;
    @(negedge clk);
    bus.start   = 1'b0;
    bus.funct3  = 3'b000;
    bus.rs1_val = 32'h1234;
    bus.rs2_val = 32'd3;
    wait_done();
    repeat (5) @(negedge clk);
    chk("hold_result", bus.result, 32'd142);

    // Back-to-back: second request issued in the done cycle.
    @(negedge clk);
    issue(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) break;
    end
    chk("b2b_done_seen", 32'(bus.done), 32'd1);
    issue(3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
    wait_done();

    // Reset in the middle of a MUL aborts with no trailing done.
    @(negedge clk);
    issue(3'b000, 32'd9, 32'd9, 32'd81, 33);
    repeat (15) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    chk("midrst_done", 32'(bus.done), 32'd0);
    chk("midrst_result", bus.result, 32'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    chk("midrst_result_held", bus.result, 32'd0);
    @(negedge clk);
    issue(3'b000, 32'd3, 32'd4, 32'd12, 33);
    wait_done();

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
